// File: rtl/ins_dispatch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// ins_dispatch_buffer_pkg
// Shared instruction-queue types: field widths, the branch opcode and the
// packed instruction record carried from decode through the dispatch buffer
// into the instruction queue.
// No ports (package).
// -----------------------------------------------------------------------------
package ins_dispatch_buffer_pkg;

  localparam int OP_W   = 4;  // opcode
  localparam int DES_W  = 4;  // destination register
  localparam int SRC1_W = 4;  // source 1
  localparam int SRC2_W = 4;  // source 2
  localparam int IME_W  = 5;  // immediate

  localparam logic [OP_W-1:0] OP_BR = 4'hC;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DES_W-1:0]  des;
    logic [SRC1_W-1:0] s1;
    logic [SRC2_W-1:0] s2;
    logic [IME_W-1:0]  ime;
  } ins_t;

  function automatic logic is_branch(input ins_t ins);
    return (ins.op == OP_BR);
  endfunction

endpackage

// File: rtl/ins_dispatch_buffer_if.sv
// -----------------------------------------------------------------------------
// ins_dispatch_buffer_if
// Bundles the fetch-side pair, the queue insertion port and the queue status
// lines seen by the dispatch buffer.
//   master : fetch/decode + instruction queue side (drives fetch pair, status)
//   slave  : the dispatch buffer (drives fe_rdy, insert port, buf_count)
// -----------------------------------------------------------------------------
interface ins_dispatch_buffer_if
  import ins_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch slot 1 (older) and slot 2 (younger)
  logic              fe_1_vld;
  logic [DES_W-1:0]  fe_1_des;
  logic [SRC1_W-1:0] fe_1_s1;
  logic [SRC2_W-1:0] fe_1_s2;
  logic [OP_W-1:0]   fe_1_op;
  logic [IME_W-1:0]  fe_1_ime;
  logic              fe_2_vld;
  logic [DES_W-1:0]  fe_2_des;
  logic [SRC1_W-1:0] fe_2_s1;
  logic [SRC2_W-1:0] fe_2_s2;
  logic [OP_W-1:0]   fe_2_op;
  logic [IME_W-1:0]  fe_2_ime;
  logic              fe_rdy;

  // queue status
  logic              entry_full;
  logic              branch_full;
  logic              flush_en;

  // queue insertion port
  logic              ins_new_1_vld;
  logic              ins_new_2_vld;
  logic [DES_W-1:0]  ins_1_des;
  logic [SRC1_W-1:0] ins_1_s1;
  logic [SRC2_W-1:0] ins_1_s2;
  logic [OP_W-1:0]   ins_1_op;
  logic [IME_W-1:0]  ins_1_ime;
  logic [DES_W-1:0]  ins_2_des;
  logic [SRC1_W-1:0] ins_2_s1;
  logic [SRC2_W-1:0] ins_2_s2;
  logic [OP_W-1:0]   ins_2_op;
  logic [IME_W-1:0]  ins_2_ime;

  logic [CNT_W-1:0]  buf_count;

  modport master (
    output fe_1_vld, fe_1_des, fe_1_s1, fe_1_s2, fe_1_op, fe_1_ime,
    output fe_2_vld, fe_2_des, fe_2_s1, fe_2_s2, fe_2_op, fe_2_ime,
    output entry_full, branch_full, flush_en,
    input  fe_rdy,
    input  ins_new_1_vld, ins_new_2_vld,
    input  ins_1_des, ins_1_s1, ins_1_s2, ins_1_op, ins_1_ime,
    input  ins_2_des, ins_2_s1, ins_2_s2, ins_2_op, ins_2_ime,
    input  buf_count
  );

  modport slave (
    input  fe_1_vld, fe_1_des, fe_1_s1, fe_1_s2, fe_1_op, fe_1_ime,
    input  fe_2_vld, fe_2_des, fe_2_s1, fe_2_s2, fe_2_op, fe_2_ime,
    input  entry_full, branch_full, flush_en,
    output fe_rdy,
    output ins_new_1_vld, ins_new_2_vld,
    output ins_1_des, ins_1_s1, ins_1_s2, ins_1_op, ins_1_ime,
    output ins_2_des, ins_2_s1, ins_2_s2, ins_2_op, ins_2_ime,
    output buf_count
  );

endinterface

// File: rtl/ins_dispatch_buffer_mem.sv
// -----------------------------------------------------------------------------
// ins_dispatch_buffer_mem
// DEPTH x ins_t storage for the dispatch buffer. Two write ports (the fetch
// pair lands at tail and tail+1) and two asynchronous read ports (head and
// head+1). Data are not reset; validity is tracked by the owner's pointers.
// Ports:
//   clk                         clock
//   wr_a_en_i/addr_i/data_i     write port A (older fetch slot)
//   wr_b_en_i/addr_i/data_i     write port B (younger fetch slot)
//   rd_a_addr_i / rd_a_data_o   read port A (head)
//   rd_b_addr_i / rd_b_data_o   read port B (head+1)
// -----------------------------------------------------------------------------
module ins_dispatch_buffer_mem
  import ins_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_a_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_a_addr_i,
  input  ins_t                     wr_a_data_i,
  input  logic                     wr_b_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_b_addr_i,
  input  ins_t                     wr_b_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_a_addr_i,
  output ins_t                     rd_a_data_o,
  input  logic [$clog2(DEPTH)-1:0] rd_b_addr_i,
  output ins_t                     rd_b_data_o
);

  ins_t mem_q [DEPTH];

  // Write both fetch slots; the owner never targets the same address twice.
  always_ff @(posedge clk) begin
    if (wr_a_en_i) begin
      mem_q[wr_a_addr_i] <= wr_a_data_i;
    end
    if (wr_b_en_i) begin
      mem_q[wr_b_addr_i] <= wr_b_data_i;
    end
  end

  assign rd_a_data_o = mem_q[rd_a_addr_i];
  assign rd_b_data_o = mem_q[rd_b_addr_i];

endmodule

// File: rtl/ins_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// ins_dispatch_buffer
// Producer-side front end of the instruction queue. Accepts up to two decoded
// instructions per cycle, holds them in program order and offers the oldest
// two to the queue insertion port, respecting entry_full, branch_full and the
// one-branch-per-cycle limit. A flush discards everything buffered.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   dispatch_if  slave side of ins_dispatch_buffer_if (fetch pair, queue
//                status, insertion port, buf_count)
// -----------------------------------------------------------------------------
module ins_dispatch_buffer
  import ins_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ins_dispatch_buffer_if.slave    dispatch_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_nxt_s, tail_nxt_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] push_n_s, pop_n_s;

  ins_t wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic fe_rdy_s, push_a_s, push_b_s, pop_a_s, pop_b_s;
  logic head_br_s, next_br_s;

  assign head_nxt_s = head_q + PTR_W'(1);
  assign tail_nxt_s = tail_q + PTR_W'(1);

  assign wr_a_s = '{op: dispatch_if.fe_1_op, des: dispatch_if.fe_1_des,
                    s1: dispatch_if.fe_1_s1, s2: dispatch_if.fe_1_s2,
                    ime: dispatch_if.fe_1_ime};
  assign wr_b_s = '{op: dispatch_if.fe_2_op, des: dispatch_if.fe_2_des,
                    s1: dispatch_if.fe_2_s1, s2: dispatch_if.fe_2_s2,
                    ime: dispatch_if.fe_2_ime};

  ins_dispatch_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk         (clk),
    .wr_a_en_i   (push_a_s),
    .wr_a_addr_i (tail_q),
    .wr_a_data_i (wr_a_s),
    .wr_b_en_i   (push_b_s),
    .wr_b_addr_i (tail_nxt_s),
    .wr_b_data_i (wr_b_s),
    .rd_a_addr_i (head_q),
    .rd_a_data_o (rd_a_s),
    .rd_b_addr_i (head_nxt_s),
    .rd_b_data_o (rd_b_s)
  );

  assign head_br_s = is_branch(rd_a_s);
  assign next_br_s = is_branch(rd_b_s);

  // Accept a fetch pair only when two free slots exist, so a pair is never split.
  always_comb begin
    fe_rdy_s = 1'b0;
    if (rst || dispatch_if.flush_en) begin
      fe_rdy_s = 1'b0;
    end else begin
      fe_rdy_s = (count_q <= CNT_W'(DEPTH - 2));
    end
  end

  assign push_a_s = fe_rdy_s && dispatch_if.fe_1_vld;
  assign push_b_s = push_a_s && dispatch_if.fe_2_vld;

  // A branch at the head needs a free branch id. The younger slot may go only
  // if it is not a branch, or if it is the single branch of this cycle.
  assign pop_a_s = (count_q >= CNT_W'(1)) && !dispatch_if.entry_full &&
                   !dispatch_if.flush_en &&
                   !(dispatch_if.branch_full && head_br_s);
  assign pop_b_s = pop_a_s && (count_q >= CNT_W'(2)) &&
                   !(next_br_s && (dispatch_if.branch_full || head_br_s));

  assign push_n_s = CNT_W'(push_a_s) + CNT_W'(push_b_s);
  assign pop_n_s  = CNT_W'(pop_a_s) + CNT_W'(pop_b_s);

  // Pointer/count next state; flush empties the buffer and beats push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (dispatch_if.flush_en) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      head_d  = head_q + pop_n_s[PTR_W-1:0];
      tail_d  = tail_q + push_n_s[PTR_W-1:0];
      count_d = count_q + push_n_s - pop_n_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dispatch_if.fe_rdy        = fe_rdy_s;
  assign dispatch_if.ins_new_1_vld = pop_a_s;
  assign dispatch_if.ins_new_2_vld = pop_b_s;
  assign dispatch_if.ins_1_op      = rd_a_s.op;
  assign dispatch_if.ins_1_des     = rd_a_s.des;
  assign dispatch_if.ins_1_s1      = rd_a_s.s1;
  assign dispatch_if.ins_1_s2      = rd_a_s.s2;
  assign dispatch_if.ins_1_ime     = rd_a_s.ime;
  assign dispatch_if.ins_2_op      = rd_b_s.op;
  assign dispatch_if.ins_2_des     = rd_b_s.des;
  assign dispatch_if.ins_2_s1      = rd_b_s.s1;
  assign dispatch_if.ins_2_s2      = rd_b_s.s2;
  assign dispatch_if.ins_2_ime     = rd_b_s.ime;
  assign dispatch_if.buf_count     = count_q;

endmodule
